wb_stage_rf: RTL and testbench

//  Write-back stage and architectural register file, the consumer end of the MEM/WB pipeline register.
//  - Selects the write-back data from the ALU result or the data-memory read value.
//  - Commits that data to a 32x32 register file.
//  - Serves the two ID-stage read ports, with same-cycle write-to-read bypass.
//  - Drives a forwarding tap to the EX stage, and keeps retire and taken-branch counters.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/rf_2r1w.sv | 37 +++
 rtl/wb_stage_rf.sv | 95 +++++++++
 tb/tb_wb_stage_rf.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: register-address width, datapath width and write-back source select.
package pipe_pkg;

  localparam int unsigned XLEN_C   = 32;
  localparam int unsigned NREGS_C  = 32;
  localparam int unsigned CNT_W_C  = 32;
  localparam int unsigned REG_AW_C = $clog2(NREGS_C);

  typedef logic [REG_AW_C-1:0] reg_addr_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_2r1w.sv
// Architectural register array: two asynchronous read ports, one synchronous write port,
// entry 0 hardwired to zero, whole array cleared by the asynchronous reset.
module rf_2r1w
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_C,
  parameter int unsigned NREGS = NREGS_C,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREGS];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/wb_stage_rf.sv
// Write-back stage: selects write-back data, commits it to the register file, bypasses it to the
// ID read ports, drives the EX forwarding tap and counts retired instructions and taken branches.
module wb_stage_rf
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_C,
  parameter int unsigned NREGS = NREGS_C,
  parameter int unsigned CNT_W = CNT_W_C,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_alu_res,
  input  logic [XLEN-1:0]  wb_dm_q,
  input  logic             wb_rf_d_sel,
  input  logic             wb_rf_we,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_next_pc,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  output logic [XLEN-1:0]  id_rs1_data,
  output logic [XLEN-1:0]  id_rs2_data,
  output logic             fwd_we,
  output logic [AW-1:0]    fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  wb_src_e         wb_src;
  logic [XLEN-1:0] wb_d;
  logic            commit;
  logic [XLEN-1:0] rf_q1;
  logic [XLEN-1:0] rf_q2;

  assign wb_src = wb_src_e'(wb_rf_d_sel);
  assign wb_d   = (wb_src == WB_SRC_MEM) ? wb_dm_q : wb_alu_res;
  assign commit = wb_valid & wb_rf_we & (wb_rd != '0) & ~rst;

  rf_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (wb_rd),
    .wdata  (wb_d),
    .raddr1 (id_rs1),
    .raddr2 (id_rs2),
    .rdata1 (rf_q1),
    .rdata2 (rf_q2)
  );

  // Same-cycle bypass so ID sees a value being committed on this edge.
  always_comb begin
    id_rs1_data = rf_q1;
    id_rs2_data = rf_q2;
    if (id_rs1 == '0) begin
      id_rs1_data = '0;
    end else if (commit && (id_rs1 == wb_rd)) begin
      id_rs1_data = wb_d;
    end
    if (id_rs2 == '0) begin
      id_rs2_data = '0;
    end else if (commit && (id_rs2 == wb_rd)) begin
      id_rs2_data = wb_d;
    end
  end

  // Tap is zeroed when idle so EX comparators never match a stale destination.
  always_comb begin
    fwd_we   = commit;
    fwd_rd   = '0;
    fwd_data = '0;
    if (commit) begin
      fwd_rd   = wb_rd;
      fwd_data = wb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      branch_cnt  <= '0;
    end else if (wb_valid) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
      if (wb_next_pc) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_rf.sv
// Randomized self-checking bench for wb_stage_rf against a behavioural register-file model.
module tb_wb_stage_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_rf_d_sel, wb_rf_we, wb_next_pc;
  logic [31:0] wb_alu_res, wb_dm_q;
  logic [4:0]  wb_rd, id_rs1, id_rs2;
  logic [31:0] id_rs1_data, id_rs2_data, fwd_data;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] retired_cnt, branch_cnt;

  // Narrow-counter instance on the same inputs, to exercise wrap-around in few cycles
  logic [31:0] w_rs1_data, w_rs2_data, w_fwd_data;
  logic        w_fwd_we;
  logic [4:0]  w_fwd_rd;
  logic [3:0]  w_retired_cnt, w_branch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf_m [32];
  logic [31:0] ret_m, br_m;

  always #5 clk = ~clk;

  wb_stage_rf dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_alu_res(wb_alu_res), .wb_dm_q(wb_dm_q),
    .wb_rf_d_sel(wb_rf_d_sel), .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_next_pc(wb_next_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retired_cnt(retired_cnt), .branch_cnt(branch_cnt)
  );

  wb_stage_rf #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_alu_res(wb_alu_res), .wb_dm_q(wb_dm_q),
    .wb_rf_d_sel(wb_rf_d_sel), .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_next_pc(wb_next_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(w_rs1_data), .id_rs2_data(w_rs2_data),
    .fwd_we(w_fwd_we), .fwd_rd(w_fwd_rd), .fwd_data(w_fwd_data),
    .retired_cnt(w_retired_cnt), .branch_cnt(w_branch_cnt)
  );

  function automatic logic model_commit();
    return wb_valid && wb_rf_we && (wb_rd != 5'd0) && !rst;
  endfunction

  function automatic logic [31:0] model_wbd();
    return wb_rf_d_sel ? wb_dm_q : wb_alu_res;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (model_commit() && (a == wb_rd)) return model_wbd();
    return rf_m[a];
  endfunction

  task automatic set_wb(input logic v, input logic we, input logic sel, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] dm, input logic np);
    wb_valid = v; wb_rf_we = we; wb_rf_d_sel = sel; wb_rd = rd;
    wb_alu_res = alu; wb_dm_q = dm; wb_next_pc = np;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    ret_m = 32'd0;
    br_m  = 32'd0;
  endtask

  // One clock edge: model applies the architectural effects of the current WB slot.
  task automatic tick();
    logic        c;
    logic [31:0] d;
    c = model_commit();
    d = model_wbd();
    @(posedge clk);
    if (!rst) begin
      if (c) rf_m[wb_rd] = d;
      if (wb_valid) ret_m = ret_m + 32'd1;
      if (wb_valid && wb_next_pc) br_m = br_m + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    set_wb(1'b1, 1'b1, 1'b0, 5'd5, 32'hA5A5_0001, 32'd0, 1'b1);
    id_rs1 = 5'd5; id_rs2 = 5'd5;
    tick(); tick();
    #1;
    n_cmp++;
    if (id_rs1_data !== 32'd0 || fwd_we !== 1'b0) begin
      n_err++; $display("FAIL reset_block_bypass: rs1=%h fwd_we=%b want 0/0", id_rs1_data, fwd_we);
    end
    n_cmp++;
    if (retired_cnt !== 32'd0 || branch_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_counters: ret=%0d br=%0d want 0/0", retired_cnt, branch_cnt);
    end
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      id_rs1 = 5'(i); id_rs2 = 5'(32 - i);
      #1;
      n_cmp++;
      if (id_rs1_data !== 32'd0 || id_rs2_data !== 32'd0) begin
        n_err++; $display("FAIL reset_rf r%0d: rs1=%h rs2=%h want 0", i, id_rs1_data, id_rs2_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_alu_write();
    set_wb(1'b1, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 1'b0);
    id_rs1 = 5'd1; id_rs2 = 5'd2;
    tick();
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    id_rs1 = 5'd5;
    #1;
    n_cmp++;
    if (id_rs1_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL alu_write: rs1=%h want deadbeef", id_rs1_data);
    end
    n_cmp++;
    if (retired_cnt !== 32'd1) begin
      n_err++; $display("FAIL alu_retire: ret=%0d want 1", retired_cnt);
    end
  endtask

  task automatic test_load_bypass();
    set_wb(1'b1, 1'b1, 1'b1, 5'd7, 32'h7777_0000, 32'h1234_5678, 1'b0);
    id_rs1 = 5'd5; id_rs2 = 5'd7;
    #1;
    n_cmp++;
    if (id_rs2_data !== 32'h1234_5678 || id_rs1_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL load_bypass: rs2=%h rs1=%h want 12345678/deadbeef", id_rs2_data, id_rs1_data);
    end
    n_cmp++;
    if (fwd_we !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL load_fwd: we=%b rd=%0d d=%h want 1/7/12345678", fwd_we, fwd_rd, fwd_data);
    end
    tick();
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    id_rs1 = 5'd7;
    #1;
    n_cmp++;
    if (id_rs1_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL load_commit: rs1=%h want 12345678", id_rs1_data);
    end
  endtask

  task automatic test_x0_write();
    logic [31:0] ret_before;
    ret_before = retired_cnt;
    set_wb(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    n_cmp++;
    if (fwd_we !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0 || id_rs1_data !== 32'd0) begin
      n_err++; $display("FAIL x0_tap: we=%b rd=%0d d=%h rs1=%h want all 0", fwd_we, fwd_rd, fwd_data, id_rs1_data);
    end
    tick();
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (id_rs1_data !== 32'd0 || id_rs2_data !== 32'd0) begin
      n_err++; $display("FAIL x0_read: rs1=%h rs2=%h want 0", id_rs1_data, id_rs2_data);
    end
    n_cmp++;
    if (retired_cnt !== ret_before + 32'd1) begin
      n_err++; $display("FAIL x0_retire: ret=%0d want %0d", retired_cnt, ret_before + 32'd1);
    end
  endtask

  task automatic test_bubble();
    set_wb(1'b0, 1'b1, 1'b0, 5'd3, 32'h55, 32'h66, 1'b1);
    id_rs1 = 5'd3; id_rs2 = 5'd3;
    #1;
    n_cmp++;
    if (fwd_we !== 1'b0 || id_rs1_data !== rf_m[3]) begin
      n_err++; $display("FAIL bubble_tap: we=%b rs1=%h want 0/%h", fwd_we, id_rs1_data, rf_m[3]);
    end
    tick();
    #1;
    n_cmp++;
    if (id_rs2_data !== rf_m[3] || retired_cnt !== ret_m || branch_cnt !== br_m) begin
      n_err++; $display("FAIL bubble_state: r3=%h ret=%0d br=%0d want %h/%0d/%0d",
                        id_rs2_data, retired_cnt, branch_cnt, rf_m[3], ret_m, br_m);
    end
  endtask

  task automatic test_random();
    logic [4:0] rd;
    for (int n = 0; n < 300; n++) begin
      rd = 5'($urandom_range(0, 31));
      set_wb(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rd,
             $urandom, $urandom, 1'($urandom));
      id_rs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      id_rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (id_rs1_data !== model_read(id_rs1) || id_rs2_data !== model_read(id_rs2)) begin
        n_err++; $display("FAIL rand_read[%0d]: rs1(%0d)=%h rs2(%0d)=%h want %h/%h", n, id_rs1, id_rs1_data,
                          id_rs2, id_rs2_data, model_read(id_rs1), model_read(id_rs2));
      end
      n_cmp++;
      if (fwd_we !== model_commit() || fwd_rd !== (model_commit() ? rd : 5'd0) ||
          fwd_data !== (model_commit() ? model_wbd() : 32'd0)) begin
        n_err++; $display("FAIL rand_fwd[%0d]: we=%b rd=%0d d=%h", n, fwd_we, fwd_rd, fwd_data);
      end
      tick();
      #1;
      n_cmp++;
      if (retired_cnt !== ret_m || branch_cnt !== br_m ||
          w_retired_cnt !== ret_m[3:0] || w_branch_cnt !== br_m[3:0]) begin
        n_err++; $display("FAIL rand_cnt[%0d]: ret=%0d br=%0d wret=%0d wbr=%0d want %0d/%0d", n,
                          retired_cnt, branch_cnt, w_retired_cnt, w_branch_cnt, ret_m, br_m);
      end
    end
  endtask

  task automatic test_counter_wrap();
    int guard = 0;
    set_wb(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    while (ret_m[3:0] != 4'hF && guard < 32) begin
      tick(); guard++;
    end
    #1;
    n_cmp++;
    if (w_retired_cnt !== 4'hF) begin
      n_err++; $display("FAIL wrap_preload: wret=%h want f", w_retired_cnt);
    end
    set_wb(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    tick();
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (w_retired_cnt !== 4'h0 || w_branch_cnt !== br_m[3:0] || branch_cnt !== br_m) begin
      n_err++; $display("FAIL wrap: wret=%h wbr=%h br=%0d want 0/%h/%0d",
                        w_retired_cnt, w_branch_cnt, branch_cnt, br_m[3:0], br_m);
    end
  endtask

  task automatic test_reset_midflight();
    set_wb(1'b1, 1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 32'd0, 1'b1);
    id_rs1 = 5'd9; id_rs2 = 5'd7;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (id_rs1_data !== 32'd0 || id_rs2_data !== 32'd0 || fwd_we !== 1'b0) begin
      n_err++; $display("FAIL midrst_comb: rs1=%h rs2=%h fwd_we=%b want 0", id_rs1_data, id_rs2_data, fwd_we);
    end
    model_reset();
    tick();
    rst = 1'b0;
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (id_rs1_data !== 32'd0 || retired_cnt !== 32'd0 || branch_cnt !== 32'd0) begin
      n_err++; $display("FAIL midrst_state: r9=%h ret=%0d br=%0d want 0", id_rs1_data, retired_cnt, branch_cnt);
    end
  endtask

  initial begin
    set_wb(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_x0_write();
    test_bubble();
    test_random();
    test_counter_wrap();
    test_reset_midflight();
    test_alu_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
